// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU codes, ALUOP selector and FSM state encoding.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_TRAP    = 4'd12
   } state_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALUOP request plus the R-type funct field to an
// ALU control code, flagging funct values the ALU cannot execute.
module mc_aludec
   import mc_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       bad_funct
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      alucontrol = ALU_ADD;
      bad_funct  = 1'b0;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: bad_funct  = 1'b1;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM with a memory ready handshake and
// illegal-instruction trap; only BRANCH pcen and FETCH load strobes see inputs.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int ALUCTL_W = 3,
   parameter bit EN_ADDI  = 1'b1,
   parameter bit EN_BNE   = 1'b1,
   parameter int STATE_W  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                memwrite,
   output logic                iord,
   output logic                irwrite,
   output logic                pcen,
   output logic [1:0]          pcsrc,
   output logic                alusrca,
   output logic [1:0]          alusrcb,
   output logic                regdst,
   output logic                memtoreg,
   output logic                regwrite,
   output logic [ALUCTL_W-1:0] alucontrol,
   output logic                illegal,
   output logic [STATE_W-1:0]  state_o
);

   state_t     state, state_next;
   aluop_t     aluop;
   logic [2:0] alu_code;
   logic       bad_funct;
   logic       is_bne, is_addi;

   assign is_bne  = EN_BNE  && (op == OP_BNE);
   assign is_addi = EN_ADDI && (op == OP_ADDI);

   mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alu_code),
      .bad_funct  (bad_funct)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:   if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            if (op == OP_LW || op == OP_SW)        state_next = S_MEMADR;
            else if (op == OP_RTYPE)               state_next = S_EXECUTE;
            else if (op == OP_BEQ || is_bne)       state_next = S_BRANCH;
            else if (is_addi)                      state_next = S_ADDIEX;
            else if (op == OP_J)                   state_next = S_JUMP;
            else                                   state_next = S_TRAP;
         end
         S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
         S_MEMWR:   if (mem_ready) state_next = S_FETCH;
         S_EXECUTE: state_next = bad_funct ? S_TRAP : S_ALUWB;
         S_ADDIEX:  state_next = S_ADDIWB;
         default:   state_next = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      pcsrc    = 2'b00;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      aluop    = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcen    = mem_ready;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            pcen    = (op == OP_BEQ) ? zero : ~zero;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB:  regwrite = 1'b1;
         S_JUMP: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         S_TRAP:    illegal = 1'b1;
         default: ;
      endcase
      // Reset aborts any access at once, not at the next edge.
      if (!reset) begin
         mem_req  = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         pcen     = 1'b0;
         regwrite = 1'b0;
         illegal  = 1'b0;
      end
   end

   assign alucontrol = ALUCTL_W'(alu_code);
   assign state_o    = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: full-featured controller plus a copy with ADDI and BNE
// disabled, both fed the same instruction stream.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;

   logic       mem_req, memwrite, iord, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, illegal;
   logic [1:0] pcsrc, alusrcb;
   logic [2:0] alucontrol;
   logic [3:0] state_o;

   logic       d2_mem_req, d2_memwrite, d2_iord, d2_irwrite, d2_pcen, d2_alusrca;
   logic       d2_regdst, d2_memtoreg, d2_regwrite, d2_illegal;
   logic [1:0] d2_pcsrc, d2_alusrcb;
   logic [2:0] d2_alucontrol;
   logic [3:0] d2_state_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
      .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alucontrol(alucontrol),
      .illegal(illegal), .state_o(state_o)
   );

   multicycle_controller #(.EN_ADDI(1'b0), .EN_BNE(1'b0)) dut2 (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(d2_mem_req), .memwrite(d2_memwrite), .iord(d2_iord), .irwrite(d2_irwrite),
      .pcen(d2_pcen), .pcsrc(d2_pcsrc), .alusrca(d2_alusrca), .alusrcb(d2_alusrcb),
      .regdst(d2_regdst), .memtoreg(d2_memtoreg), .regwrite(d2_regwrite),
      .alucontrol(d2_alucontrol), .illegal(d2_illegal), .state_o(d2_state_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction in FETCH with memory ready, walk through DECODE,
   // and leave the FSM one step into the instruction-specific state.
   task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f);
      op = o; funct = f; mem_ready = 1'b1;
      #1;
      check("fd_fetch_state", 32'(state_o), 32'd0);
      check("fd_irwrite", 32'(irwrite), 32'd1);
      tick();
      check("fd_decode_state", 32'(state_o), 32'd1);
      check("fd_decode_alusrcb", 32'(alusrcb), 32'd3);
      tick();
   endtask

   initial begin
      reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
      #12;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_irwrite", 32'(irwrite), 32'd0);
      check("rst_pcen", 32'(pcen), 32'd0);
      check("rst_memwrite", 32'(memwrite), 32'd0);
      check("rst_regwrite", 32'(regwrite), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_alusrcb", 32'(alusrcb), 32'd1);
      check("rst_alucontrol", 32'(alucontrol), 32'd2);
      check("rst_iord", 32'(iord), 32'd0);
      check("rst_pcsrc", 32'(pcsrc), 32'd0);
      check("rst_d2_state", 32'(d2_state_o), 32'd0);
      reset = 1'b1;
      #1;
      check("rel_mem_req", 32'(mem_req), 32'd1);

      // lw: FETCH DECODE MEMADR MEMRD MEMWB
      fetch_decode(6'b100011, 6'b0);
      check("lw_memadr", 32'(state_o), 32'd2);
      check("lw_memadr_alusrca", 32'(alusrca), 32'd1);
      check("lw_memadr_alusrcb", 32'(alusrcb), 32'd2);
      check("lw_memadr_regwrite", 32'(regwrite), 32'd0);
      tick();
      check("lw_memrd", 32'(state_o), 32'd3);
      check("lw_memrd_req", 32'(mem_req), 32'd1);
      check("lw_memrd_iord", 32'(iord), 32'd1);
      check("lw_memrd_regwrite", 32'(regwrite), 32'd0);
      tick();
      check("lw_memwb", 32'(state_o), 32'd4);
      check("lw_memwb_regwrite", 32'(regwrite), 32'd1);
      check("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
      check("lw_memwb_regdst", 32'(regdst), 32'd0);
      tick();
      check("lw_done", 32'(state_o), 32'd0);
      check("lw_done_regwrite", 32'(regwrite), 32'd0);

      // FETCH wait-states, then beq
      op = 6'b000100; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ws_state", 32'(state_o), 32'd0);
         check("ws_mem_req", 32'(mem_req), 32'd1);
         check("ws_irwrite", 32'(irwrite), 32'd0);
         check("ws_pcen", 32'(pcen), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("ws_last_mem_req", 32'(mem_req), 32'd1);
      check("ws_last_irwrite", 32'(irwrite), 32'd1);
      check("ws_last_pcen", 32'(pcen), 32'd1);
      tick();
      check("ws_decode", 32'(state_o), 32'd1);
      tick();
      zero = 1'b1;
      #1;
      check("beq_state", 32'(state_o), 32'd8);
      check("beq_pcsrc", 32'(pcsrc), 32'd1);
      check("beq_alucontrol", 32'(alucontrol), 32'd6);
      check("beq_alusrca", 32'(alusrca), 32'd1);
      check("beq_alusrcb", 32'(alusrcb), 32'd0);
      check("beq_z1_pcen", 32'(pcen), 32'd1);
      zero = 1'b0;
      #1;
      check("beq_z0_pcen", 32'(pcen), 32'd0);
      tick();

      // bne: branches on the full core, traps on the reduced one
      fetch_decode(6'b000101, 6'b0);
      zero = 1'b1;
      #1;
      check("bne_state", 32'(state_o), 32'd8);
      check("bne_z1_pcen", 32'(pcen), 32'd0);
      check("bne_illegal", 32'(illegal), 32'd0);
      check("d2_bne_state", 32'(d2_state_o), 32'd12);
      check("d2_bne_illegal", 32'(d2_illegal), 32'd1);
      check("d2_bne_z1_pcen", 32'(d2_pcen), 32'd0);
      zero = 1'b0;
      #1;
      check("bne_z0_pcen", 32'(pcen), 32'd1);
      check("d2_bne_z0_pcen", 32'(d2_pcen), 32'd0);
      tick();
      check("d2_bne_after_state", 32'(d2_state_o), 32'd0);
      check("d2_bne_after_illegal", 32'(d2_illegal), 32'd0);

      // R-type slt
      fetch_decode(6'b000000, 6'b101010);
      check("slt_state", 32'(state_o), 32'd6);
      check("slt_alucontrol", 32'(alucontrol), 32'd7);
      check("slt_alusrca", 32'(alusrca), 32'd1);
      check("slt_regwrite", 32'(regwrite), 32'd0);
      tick();
      check("slt_aluwb", 32'(state_o), 32'd7);
      check("slt_regwrite_wb", 32'(regwrite), 32'd1);
      check("slt_regdst", 32'(regdst), 32'd1);
      check("slt_memtoreg", 32'(memtoreg), 32'd0);
      tick();
      check("slt_done", 32'(state_o), 32'd0);

      // R-type or
      fetch_decode(6'b000000, 6'b100101);
      check("or_alucontrol", 32'(alucontrol), 32'd1);
      tick();
      check("or_aluwb", 32'(state_o), 32'd7);
      tick();

      // R-type with unsupported funct
      fetch_decode(6'b000000, 6'b000111);
      check("badfn_exec", 32'(state_o), 32'd6);
      check("badfn_exec_regwrite", 32'(regwrite), 32'd0);
      tick();
      check("badfn_trap", 32'(state_o), 32'd12);
      check("badfn_illegal", 32'(illegal), 32'd1);
      check("badfn_trap_regwrite", 32'(regwrite), 32'd0);
      tick();
      check("badfn_done", 32'(state_o), 32'd0);
      check("badfn_illegal_drop", 32'(illegal), 32'd0);

      // jump
      fetch_decode(6'b000010, 6'b0);
      check("j_state", 32'(state_o), 32'd11);
      check("j_pcsrc", 32'(pcsrc), 32'd2);
      check("j_pcen", 32'(pcen), 32'd1);
      tick();
      check("j_done", 32'(state_o), 32'd0);

      // undefined opcode
      fetch_decode(6'b111111, 6'b0);
      check("undef_trap", 32'(state_o), 32'd12);
      check("undef_illegal", 32'(illegal), 32'd1);
      tick();
      check("undef_done", 32'(state_o), 32'd0);

      // addi: executes on full core, traps on reduced one (streams diverge here)
      fetch_decode(6'b001000, 6'b0);
      check("addi_ex", 32'(state_o), 32'd9);
      check("addi_alusrca", 32'(alusrca), 32'd1);
      check("addi_alusrcb", 32'(alusrcb), 32'd2);
      check("d2_addi_trap", 32'(d2_state_o), 32'd12);
      check("d2_addi_illegal", 32'(d2_illegal), 32'd1);
      check("d2_addi_regwrite", 32'(d2_regwrite), 32'd0);
      tick();
      check("addi_wb", 32'(state_o), 32'd10);
      check("addi_wb_regwrite", 32'(regwrite), 32'd1);
      check("addi_wb_regdst", 32'(regdst), 32'd0);
      check("addi_wb_memtoreg", 32'(memtoreg), 32'd0);
      check("d2_addi_fetch", 32'(d2_state_o), 32'd0);
      check("d2_addi_no_write", 32'(d2_regwrite), 32'd0);
      tick();
      check("addi_done", 32'(state_o), 32'd0);

      // sw with wait-states, aborted by reset
      fetch_decode(6'b101011, 6'b0);
      check("sw_memadr", 32'(state_o), 32'd2);
      mem_ready = 1'b0;
      tick();
      check("sw_memwr", 32'(state_o), 32'd5);
      check("sw_mem_req", 32'(mem_req), 32'd1);
      check("sw_memwrite", 32'(memwrite), 32'd1);
      check("sw_iord", 32'(iord), 32'd1);
      tick();
      check("sw_hold", 32'(state_o), 32'd5);
      check("sw_hold_memwrite", 32'(memwrite), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_memwrite", 32'(memwrite), 32'd0);
      check("abort_mem_req", 32'(mem_req), 32'd0);
      check("abort_state", 32'(state_o), 32'd0);
      check("abort_d2_state", 32'(d2_state_o), 32'd0);
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; op = 6'b100011;
      #1;
      check("resume_fetch", 32'(state_o), 32'd0);
      check("resume_mem_req", 32'(mem_req), 32'd1);
      tick();
      check("resume_decode", 32'(state_o), 32'd1);
      check("resume_d2_decode", 32'(d2_state_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
